// File: rtl/mseq_gen_bank.sv
// Four 64-bit Fibonacci LFSRs XOR-combined into a serial keystream, packed into bytes with ready/valid flow control.
// Optional macro MSEQ_ZERO_SEED_GUARD_EN substitutes 64'h1 for an all-zero seed so no generator can lock up.
module mseq_gen_bank #(
    parameter int INPUT_DATA_WIDTH = 288
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INPUT_DATA_WIDTH-1:0] MSEQ_din,
    input  logic [3:0]                  MSEQ_din_valid,
    input  logic                        key_ready,
    output logic [7:0]                  key_byte,
    output logic                        key_valid,
    output logic [3:0]                  seeded,
    output logic                        running
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]  state;
    logic [63:0] gen [4];
    logic [7:0]  collector;
    logic [2:0]  bit_cnt;

    logic [63:0] seed_raw;
    logic [63:0] seed;
    logic        advance;
    logic        out_bit;
    logic [7:0]  next_col;

    // x^64+x^63+x^61+x^60+1, taps on bits 63/62/60/59, shifting toward the MSB
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    // The top 32 bits of the 288-bit word fold into the low half of the seed.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        seed_raw = MSEQ_din[63:0] ^ MSEQ_din[127:64] ^ MSEQ_din[191:128]
                 ^ MSEQ_din[255:192] ^ {32'h0, MSEQ_din[287:256]};
`ifdef MSEQ_ZERO_SEED_GUARD_EN
        seed = (seed_raw == 64'h0) ? 64'h0000_0000_0000_0001 : seed_raw;
`else
        seed = seed_raw;
`endif
    end

    assign running  = (state == ST_RUN);
    assign advance  = running && (!key_valid || key_ready);
    assign out_bit  = gen[0][63] ^ gen[1][63] ^ gen[2][63] ^ gen[3][63];
    assign next_col = {collector[6:0], out_bit};

    // A reseed wins over a step and is taken even while the output is stalled.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) gen[i] <= 64'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (MSEQ_din_valid[i]) begin
                    gen[i] <= seed;
                end else if (advance) begin
                    gen[i] <= lfsr_step(gen[i]);
                end
            end
        end
    end

    // The state follows the registered seeded mask, so RUN starts one edge after the last seed lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded <= 4'h0;
            state  <= ST_IDLE;
        end else begin
            seeded <= seeded | MSEQ_din_valid;
            case (state)
                ST_IDLE, ST_SEED: begin
                    if (seeded == 4'hF) begin
                        state <= ST_RUN;
                    end else if (seeded != 4'h0) begin
                        state <= ST_SEED;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Collector and counter are deliberately untouched by reseeds; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collector <= 8'h00;
            bit_cnt   <= 3'd0;
            key_byte  <= 8'h00;
            key_valid <= 1'b0;
        end else begin
            if (advance) begin
                collector <= next_col;
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (advance && (bit_cnt == 3'd7)) begin
                key_byte  <= next_col;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mseq_gen_bank.sv
// Scoreboarded bench for mseq_gen_bank: a bit-serial keystream model predicts each byte, a monitor checks handshakes.
// Honours MSEQ_ZERO_SEED_GUARD_EN the same way the design does.
module tb_mseq_gen_bank;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [287:0] din = '0;
    logic [3:0]   din_valid = 4'h0;
    logic         key_ready = 1'b0;
    logic [7:0]   key_byte;
    logic         key_valid;
    logic [3:0]   seeded;
    logic         running;

    mseq_gen_bank #(.INPUT_DATA_WIDTH(288)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MSEQ_din       (din),
        .MSEQ_din_valid (din_valid),
        .key_ready      (key_ready),
        .key_byte       (key_byte),
        .key_valid      (key_valid),
        .seeded         (seeded),
        .running        (running)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    int         n_checks = 0;
    int         n_errors = 0;
    int         consumed = 0;
    bit         auto_push = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] last_pushed = 8'h00;
    logic [63:0] mg [4];
    logic [3:0] m_seeded = 4'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT did not respond within the cycle budget", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_fold(input logic [287:0] d);
        logic [63:0] s;
        s = 64'h0;
        for (int k = 0; k < 4; k++) s ^= d[k*64 +: 64];
        s ^= {32'h0, d[287:256]};
`ifdef MSEQ_ZERO_SEED_GUARD_EN
        if (s == 64'h0) s = 64'h1;
`endif
        return s;
    endfunction

    function automatic logic [63:0] m_next(input logic [63:0] s);
        return (s << 1) | {63'h0, ^(s & TAPS)};
    endfunction

    // Produce the next 8 keystream bits; optionally reseed generators in rs_mask at bit position rs_pos.
    function automatic logic [7:0] m_byte(input int rs_pos, input logic [3:0] rs_mask, input logic [63:0] rs_val);
        logic [7:0] acc;
        logic       b;
        acc = 8'h00;
        for (int p = 0; p < 8; p++) begin
            b = mg[0][63] ^ mg[1][63] ^ mg[2][63] ^ mg[3][63];
            if (b) acc = acc | (8'h80 >> p);
            for (int g = 0; g < 4; g++) begin
                if (p == rs_pos && rs_mask[g]) mg[g] = rs_val;
                else mg[g] = m_next(mg[g]);
            end
        end
        return acc;
    endfunction

    task automatic m_load(input logic [3:0] mask, input logic [63:0] val);
        for (int g = 0; g < 4; g++) if (mask[g]) mg[g] = val;
    endtask

    task automatic push_next();
        logic [7:0] b;
        b = m_byte(-1, 4'h0, 64'h0);
        exp_q.push_back(b);
        last_pushed = b;
    endtask

    // ---------------- handshake tracking and monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && key_valid && key_ready) begin
                consumed++;
                if (auto_push) push_next();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL key_byte_unexpected: got %0h expected no byte", key_byte);
                end else begin
                    check("key_byte", {56'h0, key_byte}, {56'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [287:0] rand_din();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive_seed(input logic [287:0] d, input logic [3:0] mask);
        din       = d;
        din_valid = mask;
        tick();
        din_valid = 4'h0;
        m_seeded  = m_seeded | mask;
        check("seeded", {60'h0, seeded}, {60'h0, m_seeded});
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_key_byte", {56'h0, key_byte}, 64'h0);
        check("rst_key_valid", {63'h0, key_valid}, 64'h0);
        check("rst_seeded", {60'h0, seeded}, 64'h0);
        check("rst_running", {63'h0, running}, 64'h0);
        exp_q.delete();
        consumed = 0;
        m_seeded = 4'h0;
        for (int g = 0; g < 4; g++) mg[g] = 64'h0;
        tick();
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    // Called right after the final seeding edge with key_ready high.
    task automatic expect_first_byte();
        int  lat;
        bit  seen;
        seen = 1'b0;
        lat  = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (key_valid) begin
                lat  = e;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("first_key_valid");
        else check("first_valid_latency", lat, 9);
    endtask

    task automatic run_bytes(input int n);
        int target;
        target = consumed + n;
        for (int e = 0; e < n * 40 + 40; e++) begin
            if (consumed >= target) break;
            key_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        if (consumed < target) fail_now("run_bytes");
    endtask

    task automatic stall_on_byte();
        bit ok;
        ok = 1'b0;
        key_ready = 1'b0;
        for (int e = 0; e < 40; e++) begin
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("stall_on_byte");
    endtask

    task automatic hold_check(input int n);
        key_ready = 1'b0;
        for (int e = 0; e < n; e++) begin
            tick();
            check("hold_key_valid", {63'h0, key_valid}, 64'h1);
            check("hold_key_byte", {56'h0, key_byte}, {56'h0, last_pushed});
        end
    endtask

    task automatic stalled_reseed(input logic [3:0] mask);
        logic [287:0] d;
        d = rand_din();
        drive_seed(d, mask);
        m_load(mask, m_fold(d));
        hold_check(2);
    endtask

    // From a stalled byte: release it, then reseed mask on the edge that takes bit p of the next byte.
    task automatic midbyte_reseed(input int p, input logic [3:0] mask, input logic [287:0] d);
        logic [7:0] b;
        auto_push = 1'b0;
        b = m_byte(p, mask, m_fold(d));
        exp_q.push_back(b);
        last_pushed = b;
        key_ready = 1'b1;
        for (int j = 0; j < p; j++) tick();
        drive_seed(d, mask);
        auto_push = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [287:0] d;
        logic [3:0]   mask;
        int           guard;

        for (int g = 0; g < 4; g++) mg[g] = 64'h0;
        #1;
        check("init_key_byte", {56'h0, key_byte}, 64'h0);
        check("init_key_valid", {63'h0, key_valid}, 64'h0);
        check("init_seeded", {60'h0, seeded}, 64'h0);
        check("init_running", {63'h0, running}, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // All four generators share seed 1: identical bits cancel, bytes are zero.
        key_ready = 1'b1;
        d = '0;
        d[63:0] = 64'h1;
        drive_seed(d, 4'hF);
        m_load(4'hF, m_fold(d));
        push_next();
        expect_first_byte();
        check("identical_seed_byte", {56'h0, key_byte}, 64'h0);
        run_bytes(4);

        // Long stall holds the byte; the stream then continues where it stopped.
        stall_on_byte();
        hold_check(20);
        run_bytes(3);

        // Reseed only g1 while stalled.
        stall_on_byte();
        stalled_reseed(4'b0010);
        run_bytes(3);

        // Reseed g2 in the middle of a byte without disturbing the collector/counter.
        stall_on_byte();
        midbyte_reseed(3, 4'b0100, rand_din());
        run_bytes(3);

        // Reset in the middle of a byte, then reseed one generator at a time.
        key_ready = 1'b1;
        tick();
        tick();
        tick();
        do_reset();
        d = '0;
        d[63:0] = 64'h8000_0000_0000_0000;
        drive_seed(d, 4'b0001);
        m_load(4'b0001, m_fold(d));
        check("running_after_1", {63'h0, running}, 64'h0);
        d = '0;
        d[63:0] = 64'h1;
        drive_seed(d, 4'b0010);
        m_load(4'b0010, m_fold(d));
        drive_seed(d, 4'b0100);
        m_load(4'b0100, m_fold(d));
        for (int e = 0; e < 5; e++) tick();
        check("running_after_3", {63'h0, running}, 64'h0);
        key_ready = 1'b1;
        drive_seed(d, 4'b1000);
        m_load(4'b1000, m_fold(d));
        push_next();
        expect_first_byte();
        check("msb_seed_byte", {56'h0, key_byte}, 64'h80);
        run_bytes(3);

        // All-zero seed material.
        do_reset();
        key_ready = 1'b1;
        drive_seed('0, 4'hF);
        m_load(4'hF, m_fold('0));
        push_next();
        expect_first_byte();
        check("zero_seed_byte", {56'h0, key_byte}, 64'h0);
        run_bytes(5);

        // Randomised seeding order, flow control and reseeds.
        for (int it = 0; it < 3; it++) begin
            key_ready = 1'b0;
            do_reset();
            guard = 0;
            while (m_seeded != 4'hF) begin
                mask = 4'($urandom_range(1, 15));
                if (guard > 6) mask = ~m_seeded;
                guard++;
                d = rand_din();
                if ((m_seeded | mask) == 4'hF) begin
                    key_ready = 1'b1;
                    drive_seed(d, mask);
                    m_load(mask, m_fold(d));
                    push_next();
                    expect_first_byte();
                end else begin
                    drive_seed(d, mask);
                    m_load(mask, m_fold(d));
                    check("running_partial", {63'h0, running}, 64'h0);
                end
            end
            for (int r = 0; r < 4; r++) begin
                run_bytes(int'($urandom_range(2, 6)));
                stall_on_byte();
                hold_check(int'($urandom_range(1, 4)));
                mask = 4'($urandom_range(1, 15));
                if ($urandom_range(0, 1) == 0) stalled_reseed(mask);
                else midbyte_reseed(int'($urandom_range(0, 7)), mask, rand_din());
            end
            run_bytes(2);
        end

        key_ready = 1'b0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mseq_gen_bank.md
MSEQ_GEN_BANK -- requirements
Module: mseq_gen_bank

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 288, the width of MSEQ_din; only 288 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port MSEQ_din, input, INPUT_DATA_WIDTH, the seed material word.
REQ-005 SHALL have port MSEQ_din_valid, input, 4, a one-hot-or-multi reseed strobe: bit i targets generator i.
REQ-006 SHALL have port key_ready, input, 1, downstream accepts key_byte.
REQ-007 SHALL have port key_byte, output, 8, the keystream byte.
REQ-008 SHALL have port key_valid, output, 1, key_byte holds an unconsumed byte.
REQ-009 SHALL have port seeded, output, 4, bit i is set once generator i has been seeded.
REQ-010 SHALL have port running, output, 1, high while the FSM is in RUN.

Function
REQ-011 SHALL contain four 64-bit Fibonacci LFSRs g0..g3 with polynomial x^64+x^63+x^61+x^60+1: fb = s[63]^s[62]^s[60]^s[59]; step: s <= {s[62:0], fb}.
REQ-012 SHALL form seed = din[63:0]^din[127:64]^din[191:128]^din[255:192]^{32'h0, din[287:256]}.
REQ-013 SHALL, on an edge with MSEQ_din_valid[i]=1, load seed into gi and set seeded[i]; multiple set bits load the same seed into every targeted generator.
REQ-014 SHALL give reseed priority over a step for the same generator on the same edge; reseed occurs regardless of stall.
REQ-015 SHALL implement FSM IDLE (seeded==0) -> SEED (0<seeded<4'hF) -> RUN (seeded==4'hF); IDLE may go directly to SEED or RUN; RUN is left only by reset.
REQ-016 SHALL define advance = running && (!key_valid || key_ready); on advance, every generator not being reseeded steps once.
REQ-017 SHALL, on each advance, compute bit = g0[63]^g1[63]^g2[63]^g3[63] (pre-step values) and shift it MSB-first into an 8-bit collector with a 3-bit counter 0..7 that wraps.
REQ-018 SHALL, on the advance where the counter is 7, load {collector[6:0], bit} into key_byte and set key_valid.
REQ-019 SHALL clear key_valid on an edge with key_valid && key_ready unless a new byte is loaded on the same edge, in which case key_valid stays 1.
REQ-020 SHALL hold key_byte, the collector, the counter and all non-reseeded generators while key_valid && !key_ready.
REQ-021 SHALL NOT clear the collector or the counter on a reseed during RUN.
REQ-022 SHALL assert key_valid for the first time exactly 9 edges after the edge that sets the last seeded bit, given key_ready=1.

Reset
REQ-023 SHALL, with rst_n low, asynchronously clear all LFSRs, the collector, the counter, key_byte=8'h00, key_valid=0, seeded=4'h0, running=0, FSM=IDLE.
REQ-024 SHALL, on reset asserted mid-operation, discard any pending byte, and SHALL require four reseeds after release before output resumes.

Configuration
REQ-025 SHALL support macro MSEQ_ZERO_SEED_GUARD_EN: when defined, a computed seed of 64'h0 is replaced by 64'h0000_0000_0000_0001; when undefined, the zero seed is loaded as-is and that generator stays locked at zero.

Verification
REQ-026 SHALL cover: all four seeded with din[63:0]=64'h1, rest 0, key_ready=1 -> key_valid rises 9 edges later, key_byte=8'h00.
REQ-027 SHALL cover: g0 seeded with 64'h8000_0000_0000_0000 and g1..g3 seeded with 64'h1 -> first key_byte=8'h80.
REQ-028 SHALL cover: key_ready=0 for 20 cycles after the first byte -> key_byte/key_valid are stable; after key_ready=1 the next byte equals an unstalled reference model.
REQ-029 SHALL cover: din all-zero with valid=4'hF -> key_byte=8'h00 stream with the guard undefined; with the guard defined, g0..g3=64'h1 and bytes 8'h00 (even parity of identical bits).
REQ-030 SHALL cover: valid=4'b0010 during RUN while stalled -> only g1 is replaced, and counter and collector are unchanged.
REQ-031 SHALL cover: rst_n pulsed low mid-byte -> all outputs are 0 the same cycle; running stays 0 until four new seeds arrive.
